// File: rtl/ss_fifo_pkg.sv
// ss_fifo_pkg: shared definitions for the ss_fifo frame FIFO.
//   SS_DW / SS_AW  : default data width and address width
//   SS_LAST_BIT    : bit position of the end-of-frame tag in a storage word
//   STROBE_ON/OFF  : active-low strobe polarity for m_dst_putn / m_src_getn
package ss_fifo_pkg;
  localparam int   SS_DW       = 64;
  localparam int   SS_AW       = 4;
  localparam int   SS_LAST_BIT = SS_DW;
  localparam logic STROBE_ON   = 1'b0;
  localparam logic STROBE_OFF  = 1'b1;

  // Storage word layout: {last, data}; the tag always sits directly above the data.
  function automatic int last_pos(input int dw);
    return dw;
  endfunction
endpackage

// File: rtl/ss_fifo_ram.sv
// ss_fifo_ram: DEPTH x W storage, one synchronous write port, one
// asynchronous read port, no reset (contents survive reset and flush).
//   clk   : write clock
//   we    : write enable
//   waddr : write address,  wdata : write word
//   raddr : read address,   rdata : combinational read word
module ss_fifo_ram #(
  parameter int AW = 4,
  parameter int W  = 65
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/ss_fifo.sv
// ss_fifo: first-word-fall-through frame FIFO with per-word last tag.
//   wb_clk_i / wb_rst_i     : clock, async active-low reset
//   m_reset                 : synchronous flush (wins over put/get)
//   m_dst_putn, m_dst, m_dst_last : write side (strobe active-low)
//   m_dst_full, m_dst_almost_full : write-side occupancy flags
//   m_src_getn              : pop strobe (active-low)
//   m_src, m_src_last       : head word, valid while not empty
//   m_src_empty, m_src_almost_empty : read-side occupancy flags
//   frames                  : stored words tagged last
//   ovf / udf               : sticky write-while-full / read-while-empty
module ss_fifo
  import ss_fifo_pkg::*;
#(
  parameter int AW        = SS_AW,
  parameter int DW        = SS_DW,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          m_reset,
  input  logic          m_dst_putn,
  input  logic [DW-1:0] m_dst,
  input  logic          m_dst_last,
  output logic          m_dst_full,
  output logic          m_dst_almost_full,
  input  logic          m_src_getn,
  output logic [DW-1:0] m_src,
  output logic          m_src_last,
  output logic          m_src_empty,
  output logic          m_src_almost_empty,
  output logic [AW:0]   frames,
  output logic          ovf,
  output logic          udf
);
  localparam int          LAST  = last_pos(DW);
  localparam logic [AW:0] FULLC = (AW+1)'(2**AW);
  localparam logic [AW:0] AF_TH = FULLC - (AW+1)'(AF_MARGIN);
  localparam logic [AW:0] AE_TH = (AW+1)'(AE_MARGIN);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [DW:0]   rd_word;
  logic          put, get, wr_acc, rd_acc, wr_last, rd_last;

  assign put     = (m_dst_putn == STROBE_ON);
  assign get     = (m_src_getn == STROBE_ON);
  // Full blocks writes even when a pop happens in the same cycle.
  assign wr_acc  = put && !m_dst_full;
  assign rd_acc  = get && !m_src_empty;
  assign wr_last = wr_acc && m_dst_last;
  assign rd_last = rd_acc && rd_word[LAST];

  ss_fifo_ram #(.AW(AW), .W(DW+1)) u_ram (
    .clk   (wb_clk_i),
    .we    (wr_acc && !m_reset),
    .waddr (wr_ptr),
    .wdata ({m_dst_last, m_dst}),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      frames <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (m_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      frames <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({wr_last, rd_last})
        2'b10:   frames <= frames + 1'b1;
        2'b01:   frames <= frames - 1'b1;
        default: frames <= frames;
      endcase
      if (put && m_dst_full)  ovf <= 1'b1;
      if (get && m_src_empty) udf <= 1'b1;
    end
  end

  assign m_src              = rd_word[DW-1:0];
  assign m_src_last         = rd_word[LAST];
  assign m_dst_full         = (count == FULLC);
  assign m_dst_almost_full  = (count >= AF_TH);
  assign m_src_empty        = (count == '0);
  assign m_src_almost_empty = (count <= AE_TH);
endmodule

// File: doc/ss_fifo.md
Name: ss_fifo

Overview:
- 64-bit synchronous frame FIFO. It is the opposite end of the engine-side m_src/m_dst FIFO ports.
- A data-path channel consumes from the m_src read port and produces into the m_dst write port. This block is the storage that serves both.
- Each word carries a last (end-of-frame) tag.
- Occupancy flags follow fixed thresholds. A synchronous flush input mirrors m_reset.
- One instance sits on each DMA channel's source side and one on its destination side.

Parameters:
- AW, 4, address width; DEPTH = 2**AW entries.
- DW, 64, data width.
- AF_MARGIN, 2; m_dst_almost_full asserts when count >= DEPTH-AF_MARGIN.
- AE_MARGIN, 2; m_src_almost_empty asserts when count <= AE_MARGIN.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous assert, active-low (0 = reset).
- m_reset  in  1  synchronous flush, active-high.
- m_dst_putn  in  1  write strobe, active-low.
- m_dst  in  DW  write data.
- m_dst_last  in  1  end-of-frame tag for the written word.
- m_dst_full  out  1  count == DEPTH.
- m_dst_almost_full  out  1  count >= DEPTH-AF_MARGIN.
- m_src_getn  in  1  read/pop strobe, active-low.
- m_src  out  DW  head word (first-word-fall-through).
- m_src_last  out  1  tag of the head word.
- m_src_empty  out  1  count == 0.
- m_src_almost_empty  out  1  count <= AE_MARGIN.
- frames  out  AW+1  number of stored words tagged last.
- ovf  out  1  sticky: a write was attempted while full.
- udf  out  1  sticky: a read was attempted while empty.

Behaviour:
- State registers:
  - wr_ptr, rd_ptr are AW bits and wrap modulo DEPTH naturally.
  - count is AW+1 bits.
  - frames is AW+1 bits.
  - ovf and udf are 1 bit each.
  - Storage is DEPTH x (DW+1): data plus last.
- Reset (wb_rst_i=0, asynchronous):
  - Pointers, count, frames, ovf and udf go to 0.
  - Outputs become m_src_empty=1, m_src_almost_empty=1, m_dst_full=0, m_dst_almost_full=0.
  - m_src and m_src_last are don't-care while empty; a bench must not check them.
  - Storage is not cleared.
- Flush (m_reset=1 at an edge):
  - Same register effect as reset, including clearing ovf and udf.
  - Flush overrides any put or get in the same cycle; that put or get is ignored.
- Write accept:
  - Condition: m_dst_putn==0 && count<DEPTH.
  - Effect: mem[wr_ptr] <= {m_dst_last, m_dst}; wr_ptr increments.
- Write when full:
  - The write is dropped and ovf <= 1.
  - This holds even if a read occurs in the same cycle. Full means no write, which keeps the behaviour deterministic.
- Read accept:
  - Condition: m_src_getn==0 && count>0.
  - Effect: the head entry is popped and rd_ptr increments.
- Read when empty:
  - Ignored and udf <= 1.
  - A write in the same cycle still proceeds.
- FWFT:
  - m_src and m_src_last show mem[rd_ptr] combinationally from the registered pointer.
  - A word written at edge N is visible on m_src after edge N; read latency from write is 1 cycle.
  - A pop at edge N exposes the next word after edge N.
- count update:
  - +1 on write-only, -1 on read-only.
  - Unchanged on simultaneous accepted write and read. That case requires 0<count<DEPTH.
- frames update:
  - +1 when an accepted write has last=1.
  - -1 when an accepted read pops a head with last=1.
  - Both in the same cycle: unchanged.
- Flags:
  - All flags decode combinationally from registered count.
  - They are therefore glitch-free relative to the clock and update 1 cycle after the causing edge.
- Boundary: count never exceeds DEPTH or goes below 0. An assertion in the bench checks this.

Decomposition:
- Shared header ss_defs holds:
  - DW and the default AW;
  - the last-bit position (bit DW of a storage word);
  - the active-low strobe polarity constants.
- One sub-module, ss_fifo_ram:
  - DEPTH x (DW+1), one synchronous write port, one asynchronous read port;
  - no reset.
- The pointers, count, frames and flag logic stay in ss_fifo.

Test Plan:
- Reset and first word:
  - Stimulus: hold wb_rst_i=0 for 3 cycles, release, then put 0x0123456789ABCDEF with last=0.
  - Required before the put: empty=1, almost_empty=1, frames=0.
  - Required after the edge: m_src=0x0123456789ABCDEF, empty=0, count 1.
- Fill to full:
  - Stimulus: 16 writes of data=i, with last=1 on i=7 and i=15.
  - Required: almost_full rises after write 14; full after write 16; frames=2.
  - Stimulus: a 17th write of 0xDEAD.
  - Required: dropped, ovf=1, and a later drain returns exactly 0..15 in order.
- Drain and underflow:
  - Stimulus: pop all 16 words.
  - Required: m_src_last=1 exactly on words 7 and 15; frames falls 2->1->0; almost_empty rises when count=2; empty=1.
  - Stimulus: one further getn=0.
  - Required: udf=1, count stays 0.
- Simultaneous put and get at count=5 for 20 cycles:
  - Required: count stays 5, pointers wrap past 15->0, data order preserved.
- Flush mid-stream:
  - Stimulus: at count=9, frames=3, drive m_reset=1 together with putn=0.
  - Required: the next cycle shows count=0, frames=0, empty=1, ovf=udf=0, and the put is discarded.
- Async reset mid-operation:
  - Stimulus: drop wb_rst_i between clock edges while count=4.
  - Required: empty=1 immediately, before the next edge; after release the FIFO accepts writes normally.
